// File: rtl/rpt_evt_collector_pkg.sv
// Shared report types and the timestamped record format that the collector buffers.
// Record src is sized for the largest supported source count (8).
package rpt_hw_pkg;

  localparam int SRC_W = 3;

  typedef enum logic [1:0] {
    RPT_INFO    = 2'd0,
    RPT_WARNING = 2'd1,
    RPT_ERROR   = 2'd2,
    RPT_FATAL   = 2'd3
  } report_t;

  typedef enum logic [1:0] {
    SEV_LOW    = 2'd0,
    SEV_MEDIUM = 2'd1,
    SEV_HIGH   = 2'd2,
    SEV_TOP    = 2'd3
  } severity_t;

  typedef enum logic [1:0] {
    ACT_LOG     = 2'd0,
    ACT_STOP    = 2'd1,
    ACT_EXIT    = 2'd2,
    ACT_LOG_ALT = 2'd3
  } action_t;

  typedef struct packed {
    logic [SRC_W-1:0] src;
    report_t          rtype;
    severity_t        sev;
    logic [7:0]       code;
    logic [31:0]      ts;
  } rpt_rec_t;

endpackage

// File: rtl/rpt_evt_collector_if.sv
// Event strobes from the checkers plus the valid/ready record stream to the logger.
// slave = collector side, master = environment side.
interface rpt_evt_collector_if #(
  parameter int NSRC = 4
);
  localparam int SRCW = $clog2(NSRC);

  logic [NSRC-1:0]   evt_vld;
  logic [2*NSRC-1:0] evt_type;
  logic [2*NSRC-1:0] evt_sev;
  logic [2*NSRC-1:0] evt_act;
  logic [8*NSRC-1:0] evt_code;

  logic              rec_vld;
  logic              rec_rdy;
  logic [SRCW-1:0]   rec_src;
  logic [1:0]        rec_type;
  logic [1:0]        rec_sev;
  logic [7:0]        rec_code;
  logic [31:0]       rec_time;

  modport master (
    output evt_vld, evt_type, evt_sev, evt_act, evt_code, rec_rdy,
    input  rec_vld, rec_src, rec_type, rec_sev, rec_code, rec_time
  );

  modport slave (
    input  evt_vld, evt_type, evt_sev, evt_act, evt_code, rec_rdy,
    output rec_vld, rec_src, rec_type, rec_sev, rec_code, rec_time
  );

endinterface

// File: rtl/rpt_rec_fifo.sv
// First-word-fall-through record FIFO; head visible the cycle after a push, zero when empty.
// A push while full is accepted only together with a pop (occupancy unchanged).
module rpt_rec_fifo import rpt_hw_pkg::*; #(
  parameter int DEPTH = 8
) (
  input  logic     clk_i,
  input  logic     rstn_i,
  input  logic     push_i,
  input  rpt_rec_t din_i,
  input  logic     pop_i,
  output rpt_rec_t dout_o,
  output logic     full_o,
  output logic     empty_o
);
  localparam int AW = $clog2(DEPTH);

  rpt_rec_t    mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic        do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + (AW+1)'(1);
      if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/rpt_evt_collector.sv
// Counts checker events by type, forwards those above threshold via per-source slots, a
// round-robin arbiter and a FWFT FIFO (event t -> rec_vld t+2); a busy slot drops the event.
module rpt_evt_collector import rpt_hw_pkg::*; #(
  parameter int NSRC  = 4,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  rpt_evt_collector_if.slave    bus,
  input  logic [1:0]            svrt_thr_i,
  input  logic                  clr_i,
  output logic [CNT_W-1:0]      info_cnt_o,
  output logic [CNT_W-1:0]      warn_cnt_o,
  output logic [CNT_W-1:0]      err_cnt_o,
  output logic [CNT_W-1:0]      fatal_cnt_o,
  output logic [CNT_W-1:0]      drop_cnt_o,
  output logic                  stop_o,
  output logic                  exit_o
);
  localparam int SRCW = $clog2(NSRC);
  localparam int IW   = $clog2(NSRC + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  logic [31:0]     timer_q;
  cnt_t            cnt_q [4];
  cnt_t            cnt_d [4];
  cnt_t            drop_q, drop_d;
  logic            stop_q, stop_d, exit_q, exit_d;
  rpt_rec_t        slot_q [NSRC];
  rpt_rec_t        slot_d [NSRC];
  logic [NSRC-1:0] slot_vld_q, slot_vld_d;
  logic [SRCW-1:0] last_q, last_d;

  logic [IW-1:0]   inc [4];
  logic [IW-1:0]   drop_inc;
  logic [NSRC-1:0] pass;
  logic            any_stop, any_exit;
  logic            can_grant, gnt_vld, pop;
  logic [SRCW-1:0] gnt_idx;
  int              idx;
  logic            fifo_full, fifo_empty;
  rpt_rec_t        fifo_dout;

  function automatic cnt_t sat_add(input cnt_t a, input logic [IW-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  always_comb begin
    inc      = '{default: '0};
    pass     = '0;
    any_stop = 1'b0;
    any_exit = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (bus.evt_vld[i]) begin
        inc[bus.evt_type[2*i +: 2]] = inc[bus.evt_type[2*i +: 2]] + IW'(1);
        if (bus.evt_sev[2*i +: 2] > svrt_thr_i) begin
          pass[i] = 1'b1;
          if (action_t'(bus.evt_act[2*i +: 2]) == ACT_STOP) any_stop = 1'b1;
          if (action_t'(bus.evt_act[2*i +: 2]) == ACT_EXIT) any_exit = 1'b1;
        end
      end
    end
  end

  // Round-robin: search starts just after the last granted source.
  assign pop       = !fifo_empty && bus.rec_rdy;
  assign can_grant = !fifo_full || pop;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = 1; k <= NSRC; k++) begin
      idx = int'(last_q) + k;
      if (idx >= NSRC) idx = idx - NSRC;
      if (can_grant && !gnt_vld && slot_vld_q[SRCW'(idx)]) begin
        gnt_vld = 1'b1;
        gnt_idx = SRCW'(idx);
      end
    end
  end

  assign last_d = gnt_vld ? gnt_idx : last_q;

  // A slot being granted this cycle is free to take the new event.
  always_comb begin
    slot_d     = slot_q;
    slot_vld_d = slot_vld_q;
    drop_inc   = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (gnt_vld && gnt_idx == SRCW'(i)) slot_vld_d[i] = 1'b0;
      if (pass[i] && !slot_vld_d[i]) begin
        slot_vld_d[i] = 1'b1;
        slot_d[i]     = '{src:   SRC_W'(i),
                          rtype: report_t'(bus.evt_type[2*i +: 2]),
                          sev:   severity_t'(bus.evt_sev[2*i +: 2]),
                          code:  bus.evt_code[8*i +: 8],
                          ts:    timer_q};
      end else if (pass[i]) begin
        drop_inc = drop_inc + IW'(1);
      end
    end
  end

  always_comb begin
    for (int t = 0; t < 4; t++) cnt_d[t] = clr_i ? '0 : sat_add(cnt_q[t], inc[t]);
    drop_d = clr_i ? '0 : sat_add(drop_q, drop_inc);
    stop_d = clr_i ? 1'b0 : (stop_q | any_stop);
    exit_d = exit_q | any_exit;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      timer_q    <= '0;
      for (int t = 0; t < 4; t++) cnt_q[t] <= '0;
      drop_q     <= '0;
      stop_q     <= 1'b0;
      exit_q     <= 1'b0;
      for (int i = 0; i < NSRC; i++) slot_q[i] <= '0;
      slot_vld_q <= '0;
      last_q     <= SRCW'(NSRC - 1);
    end else begin
      timer_q    <= timer_q + 32'd1;
      cnt_q      <= cnt_d;
      drop_q     <= drop_d;
      stop_q     <= stop_d;
      exit_q     <= exit_d;
      slot_q     <= slot_d;
      slot_vld_q <= slot_vld_d;
      last_q     <= last_d;
    end
  end

  rpt_rec_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (gnt_vld),
    .din_i   (slot_q[gnt_idx]),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.rec_vld  = !fifo_empty;
  assign bus.rec_src  = SRCW'(fifo_dout.src);
  assign bus.rec_type = fifo_dout.rtype;
  assign bus.rec_sev  = fifo_dout.sev;
  assign bus.rec_code = fifo_dout.code;
  assign bus.rec_time = fifo_dout.ts;

  assign info_cnt_o  = cnt_q[0];
  assign warn_cnt_o  = cnt_q[1];
  assign err_cnt_o   = cnt_q[2];
  assign fatal_cnt_o = cnt_q[3];
  assign drop_cnt_o  = drop_q;
  assign stop_o      = stop_q;
  assign exit_o      = exit_q;

endmodule

// File: tb/tb_rpt_evt_collector.sv
// Directed and random stimulus for rpt_evt_collector checked against a queue-based model
// of the counting, slot, round-robin and record-FIFO rules.
module tb_rpt_evt_collector;
  import rpt_hw_pkg::*;

  localparam int NSRC  = 4;
  localparam int DEPTH = 8;
  localparam int CNT_W = 16;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rstn, clr;
  logic [1:0]       thr;
  logic [CNT_W-1:0] info_cnt, warn_cnt, err_cnt, fatal_cnt, drop_cnt;
  logic             stop_f, exit_f;

  rpt_evt_collector_if #(.NSRC(NSRC)) bus ();

  rpt_evt_collector #(.NSRC(NSRC), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rstn_i(rstn), .bus(bus), .svrt_thr_i(thr), .clr_i(clr),
    .info_cnt_o(info_cnt), .warn_cnt_o(warn_cnt), .err_cnt_o(err_cnt),
    .fatal_cnt_o(fatal_cnt), .drop_cnt_o(drop_cnt), .stop_o(stop_f), .exit_o(exit_f)
  );

  always #5 clk = ~clk;

  // Behavioural model: each cycle pop, grant one occupied slot into the FIFO, then offer events.
  int          m_cnt [4];
  int          m_drop;
  bit          m_stop, m_exit;
  logic [31:0] m_time;
  rpt_rec_t    m_slot [NSRC];
  bit          m_slot_v [NSRC];
  rpt_rec_t    m_q [$];
  int          m_last;

  always @(posedge clk) begin
    int  inc [4];
    int  ndrop, gi, idx;
    bit  pop, st, ex;
    if (!rstn) begin
      for (int t = 0; t < 4; t++) m_cnt[t] = 0;
      m_drop = 0; m_stop = 0; m_exit = 0; m_time = 0;
      for (int i = 0; i < NSRC; i++) m_slot_v[i] = 0;
      m_q.delete();
      m_last = NSRC - 1;
    end else begin
      pop = (m_q.size() > 0) && bus.rec_rdy;
      gi  = -1;
      if (m_q.size() < DEPTH || pop)
        for (int k = 1; k <= NSRC; k++) begin
          idx = (m_last + k) % NSRC;
          if (gi < 0 && m_slot_v[idx]) gi = idx;
        end
      if (pop) void'(m_q.pop_front());
      if (gi >= 0) begin
        m_q.push_back(m_slot[gi]);
        m_slot_v[gi] = 0;
        m_last = gi;
      end
      for (int t = 0; t < 4; t++) inc[t] = 0;
      ndrop = 0; st = 0; ex = 0;
      for (int i = 0; i < NSRC; i++) begin
        if (bus.evt_vld[i]) begin
          inc[bus.evt_type[2*i +: 2]]++;
          if (bus.evt_sev[2*i +: 2] > thr) begin
            if (bus.evt_act[2*i +: 2] == 2'd1) st = 1;
            if (bus.evt_act[2*i +: 2] == 2'd2) ex = 1;
            if (!m_slot_v[i]) begin
              m_slot_v[i] = 1;
              m_slot[i] = '{src: 3'(i), rtype: report_t'(bus.evt_type[2*i +: 2]),
                            sev: severity_t'(bus.evt_sev[2*i +: 2]),
                            code: bus.evt_code[8*i +: 8], ts: m_time};
            end else ndrop++;
          end
        end
      end
      if (clr) begin
        for (int t = 0; t < 4; t++) m_cnt[t] = 0;
        m_drop = 0; m_stop = 0;
      end else begin
        for (int t = 0; t < 4; t++) m_cnt[t] = (m_cnt[t] + inc[t] > CMAX) ? CMAX : m_cnt[t] + inc[t];
        m_drop = (m_drop + ndrop > CMAX) ? CMAX : m_drop + ndrop;
        if (st) m_stop = 1;
      end
      if (ex) m_exit = 1;
      m_time = m_time + 32'd1;
    end
  end

  int npass = 0, ntot = 0, nfail = 0;
  bit chk_en = 1'b1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model();
    chk("rec_vld", 64'(bus.rec_vld), 64'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      chk("rec_src",  64'(bus.rec_src),  64'(m_q[0].src[1:0]));
      chk("rec_type", 64'(bus.rec_type), 64'(m_q[0].rtype));
      chk("rec_sev",  64'(bus.rec_sev),  64'(m_q[0].sev));
      chk("rec_code", 64'(bus.rec_code), 64'(m_q[0].code));
      chk("rec_time", 64'(bus.rec_time), 64'(m_q[0].ts));
    end
    chk("info_cnt",  64'(info_cnt),  64'(m_cnt[0]));
    chk("warn_cnt",  64'(warn_cnt),  64'(m_cnt[1]));
    chk("err_cnt",   64'(err_cnt),   64'(m_cnt[2]));
    chk("fatal_cnt", 64'(fatal_cnt), 64'(m_cnt[3]));
    chk("drop_cnt",  64'(drop_cnt),  64'(m_drop));
    chk("stop",      64'(stop_f),    64'(m_stop));
    chk("exit",      64'(exit_f),    64'(m_exit));
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (chk_en) chk_model();
  endtask

  task automatic clr_evt();
    bus.evt_vld = '0; bus.evt_type = '0; bus.evt_sev = '0; bus.evt_act = '0; bus.evt_code = '0;
  endtask

  task automatic set_evt(input int i, input logic [1:0] ty, input logic [1:0] sv,
                         input logic [1:0] ac, input logic [7:0] cd);
    bus.evt_vld[i]        = 1'b1;
    bus.evt_type[2*i +: 2] = ty;
    bus.evt_sev[2*i +: 2]  = sv;
    bus.evt_act[2*i +: 2]  = ac;
    bus.evt_code[8*i +: 8] = cd;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  logic [7:0] codes [12];

  initial begin
    rstn = 1'b0; clr = 1'b0; thr = 2'd0; bus.rec_rdy = 1'b1;
    clr_evt();
    @(negedge clk);
    repeat (3) tick();
    chk("rst_rec_vld",  64'(bus.rec_vld),  64'd0);
    chk("rst_rec_code", 64'(bus.rec_code), 64'd0);
    chk("rst_rec_time", 64'(bus.rec_time), 64'd0);
    chk("rst_err_cnt",  64'(err_cnt),      64'd0);
    chk("rst_stop",     64'(stop_f),       64'd0);
    chk("rst_exit",     64'(exit_f),       64'd0);
    rstn = 1'b1;

    // Single passing event at timer 10 -> record at cycle 12.
    repeat (10) tick();
    set_evt(1, 2'd2, 2'd2, 2'd0, 8'h5A);
    tick(); clr_evt();
    chk("t1_err_cnt",  64'(err_cnt),      64'd1);
    chk("t1_vld_t11",  64'(bus.rec_vld),  64'd0);
    tick();
    chk("t1_vld_t12",  64'(bus.rec_vld),  64'd1);
    chk("t1_src",      64'(bus.rec_src),  64'd1);
    chk("t1_type",     64'(bus.rec_type), 64'd2);
    chk("t1_sev",      64'(bus.rec_sev),  64'd2);
    chk("t1_code",     64'(bus.rec_code), 64'h5A);
    chk("t1_time",     64'(bus.rec_time), 64'd10);
    tick();

    // Filtered STOP: counted only.
    thr = 2'd2;
    set_evt(0, 2'd1, 2'd1, 2'd1, 8'($urandom));
    tick(); clr_evt();
    chk("t2_warn_cnt", 64'(warn_cnt), 64'd1);
    chk("t2_stop",     64'(stop_f),   64'd0);
    tick();
    chk("t2_no_rec",   64'(bus.rec_vld), 64'd0);

    // Four simultaneous INFO events drain in source order.
    do_reset();
    thr = 2'd1;
    for (int i = 0; i < NSRC; i++) begin
      codes[i] = 8'($urandom);
      set_evt(i, 2'd0, 2'd3, 2'd0, codes[i]);
    end
    tick(); clr_evt();
    chk("t3_info_cnt", 64'(info_cnt), 64'd4);
    tick();
    for (int k = 0; k < NSRC; k++) begin
      chk("t3_vld",  64'(bus.rec_vld),  64'd1);
      chk("t3_src",  64'(bus.rec_src),  64'(k));
      chk("t3_code", 64'(bus.rec_code), 64'(codes[k]));
      tick();
    end
    chk("t3_empty", 64'(bus.rec_vld), 64'd0);

    // Backpressure: 12 events from src2 -> 8 in FIFO, 1 in slot, 3 dropped.
    bus.rec_rdy = 1'b0; thr = 2'd0;
    for (int j = 0; j < 12; j++) begin
      codes[j] = 8'($urandom);
      set_evt(2, 2'($urandom), 2'($urandom_range(1, 3)), 2'd0, codes[j]);
      tick(); clr_evt();
    end
    chk("t4_drop_cnt", 64'(drop_cnt), 64'd3);
    bus.rec_rdy = 1'b1;
    for (int k = 0; k < 9; k++) begin
      chk("t4_vld",  64'(bus.rec_vld),  64'd1);
      chk("t4_src",  64'(bus.rec_src),  64'd2);
      chk("t4_code", 64'(bus.rec_code), 64'(codes[k]));
      tick();
    end
    chk("t4_empty", 64'(bus.rec_vld), 64'd0);

    // Random traffic with random backpressure and threshold.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      clr_evt();
      if (n % 50 == 0) thr = 2'($urandom);
      bus.rec_rdy = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NSRC; i++)
        if ($urandom_range(0, 2) == 0)
          set_evt(i, 2'($urandom), 2'($urandom), 2'($urandom), 8'($urandom));
      tick();
    end
    clr_evt(); bus.rec_rdy = 1'b1;
    repeat (20) tick();

    // ERROR counter saturation, then clear beating a same-cycle increment.
    do_reset();
    thr = 2'd3; chk_en = 1'b0;
    for (int i = 0; i < NSRC; i++) set_evt(i, 2'd2, 2'd0, 2'd0, 8'd0);
    repeat (16383) tick();
    clr_evt();
    for (int i = 0; i < 3; i++) set_evt(i, 2'd2, 2'd0, 2'd0, 8'd0);
    tick();
    chk_en = 1'b1;
    clr_evt();
    tick();
    chk("t5_err_65535", 64'(err_cnt), 64'hFFFF);
    set_evt(0, 2'd2, 2'd0, 2'd0, 8'd0);
    tick(); clr_evt();
    chk("t5_err_sat", 64'(err_cnt), 64'hFFFF);
    set_evt(1, 2'd2, 2'd0, 2'd0, 8'd0);
    clr = 1'b1;
    tick();
    clr = 1'b0; clr_evt();
    chk("t5_err_clr",  64'(err_cnt),  64'd0);
    chk("t5_drop_clr", 64'(drop_cnt), 64'd0);

    // STOP is sticky until clr.
    thr = 2'd0;
    set_evt(0, 2'd1, 2'd1, 2'd1, 8'h11);
    tick(); clr_evt();
    chk("t6_stop_set", 64'(stop_f), 64'd1);
    tick();
    chk("t6_stop_hold", 64'(stop_f), 64'd1);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("t6_stop_clr", 64'(stop_f), 64'd0);

    // EXIT survives clr, cleared only by reset.
    thr = 2'd2;
    set_evt(3, 2'd3, 2'd3, 2'd2, 8'($urandom));
    tick(); clr_evt();
    chk("t7_exit_set",  64'(exit_f),    64'd1);
    chk("t7_fatal_cnt", 64'(fatal_cnt), 64'd1);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("t7_exit_clr",  64'(exit_f),    64'd1);
    chk("t7_fatal_clr", 64'(fatal_cnt), 64'd0);
    do_reset();
    chk("t7_exit_rst",  64'(exit_f),      64'd0);
    chk("t7_fifo_rst",  64'(bus.rec_vld), 64'd0);
    tick();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
